// File: rtl/tc77_reader.sv
// Reads one 16-bit word from a TC77 over its 3-wire bus on an active-low request.
// The word is repacked as {T[12:0], CONV_DONE} for the fan-control FSM.
module tc77_reader #(
  parameter int unsigned CLKDIV   = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_GAP   = 8
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        nLOAD,
  output logic        nCOMPLETE,
  output logic        BUSY,
  output logic [13:0] TEMPDATA,
  output logic        nTEMPCS,
  inout  wire         TEMPSIO,
  output logic        TEMPCLK
);

  localparam int unsigned MAX_A = (CLKDIV > CS_SETUP) ? CLKDIV : CS_SETUP;
  localparam int unsigned MAXP  = (MAX_A > CS_GAP) ? MAX_A : CS_GAP;
  localparam int unsigned CW    = $clog2(MAXP + 1);

  localparam logic [CW-1:0] DIV_LAST   = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  // DONE already accounts for the first high cycle of the gap.
  localparam logic [CW-1:0] GAP_LOAD   = (CS_GAP > 1) ? CW'(CS_GAP - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCK_LO,
    S_SCK_HI,
    S_DONE,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    bit_q;
  logic [15:0]   sr_q;
  logic          cs_n_q;
  logic          sck_q;
  logic          cmpl_n_q;
  logic          busy_q;
  logic [13:0]   data_q;

  // TEMPSIO is never driven here; the TC77 owns the line.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      cmpl_n_q <= 1'b1;
      busy_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!nLOAD) begin
            state_q <= S_SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= SETUP_LAST;
            bit_q   <= '0;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_SCK_LO;
            cnt_q   <= DIV_LAST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SCK_LO: begin
          if (cnt_q == '0) begin
            state_q <= S_SCK_HI;
            sck_q   <= 1'b1;
            sr_q    <= {sr_q[14:0], TEMPSIO};
            bit_q   <= bit_q + 5'd1;
            cnt_q   <= DIV_LAST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_SCK_HI: begin
          if (cnt_q == '0) begin
            sck_q <= 1'b0;
            if (bit_q == 5'd16) begin
              state_q  <= S_DONE;
              cs_n_q   <= 1'b1;
              data_q   <= sr_q[15:2];
              cmpl_n_q <= 1'b0;
            end else begin
              state_q <= S_SCK_LO;
              cnt_q   <= DIV_LAST;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          cmpl_n_q <= 1'b1;
          if (CS_GAP <= 1) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_GAP;
            cnt_q   <= GAP_LOAD;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nTEMPCS   = cs_n_q;
  assign TEMPCLK   = sck_q;
  assign nCOMPLETE = cmpl_n_q;
  assign BUSY      = busy_q;
  assign TEMPDATA  = data_q;

endmodule
